fault_sim_sequencer: RTL and testbench

//  Controller for serial stuck-at fault simulation of a gate-level netlist built from fault-injectable primitives.

---
 rtl/fault_sim_pkg.sv | 38 +++
 rtl/fault_sim_sequencer_if.sv | 36 +++
 rtl/fault_sim_sequencer_settle_timer.sv | 47 ++++
 rtl/fault_sim_sequencer.sv | 176 +++++++++++++++++
 tb/tb_fault_sim_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/fault_sim_pkg.sv
// Shared definitions for the stuck-at fault simulation sequencer.
// Holds the netlist geometry (input/output/fault-site counts), derived
// widths, the controller state encoding and the per-fault result record.
package fault_sim_pkg;

   // Netlist-under-test geometry
   localparam int N_IN      = 3;
   localparam int N_OUT     = 2;
   localparam int N_FAULTS  = 21;

   // Derived widths and counts
   localparam int SITE_W    = (N_FAULTS > 1) ? $clog2(N_FAULTS) : 1;
   localparam int N_REPORTS = 2 * N_FAULTS;
   localparam int CNT_W     = $clog2(N_REPORTS + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INJECT  = 3'd1,
      APPLY   = 3'd2,
      SETTLE  = 3'd3,
      COMPARE = 3'd4,
      REPORT  = 3'd5,
      DONE    = 3'd6
   } state_e;

   typedef struct packed {
      logic [SITE_W-1:0] site;
      logic              sa;
      logic              det;
      logic [N_IN-1:0]   vec;
   } result_t;

   // True for the final fault of the walk: highest site, stuck-at-1.
   function automatic logic is_last_fault(input logic [SITE_W-1:0] site, input logic sa);
      return (site == SITE_W'(N_FAULTS - 1)) && sa;
   endfunction

endpackage

// File: rtl/fault_sim_sequencer_if.sv
// Bus between the fault sequencer and its environment.
//   vec_out / fault_en / fault_site / fault_sa : stimulus + injection control
//   golden_in / faulty_in                      : outputs of the two netlist copies
//   res_valid / res_ready / res_*              : per-fault result handshake
//   det_count                                  : detected faults this campaign
// master = sequencer, slave = host + netlist pair.
interface fault_sim_sequencer_if;
   import fault_sim_pkg::*;

   logic [N_IN-1:0]   vec_out;
   logic              fault_en;
   logic [SITE_W-1:0] fault_site;
   logic              fault_sa;
   logic [N_OUT-1:0]  golden_in;
   logic [N_OUT-1:0]  faulty_in;
   logic              res_valid;
   logic              res_ready;
   logic [SITE_W-1:0] res_site;
   logic              res_sa;
   logic              res_det;
   logic [N_IN-1:0]   res_vec;
   logic [CNT_W-1:0]  det_count;

   modport master (
      output vec_out, fault_en, fault_site, fault_sa,
      output res_valid, res_site, res_sa, res_det, res_vec, det_count,
      input  golden_in, faulty_in, res_ready
   );

   modport slave (
      input  vec_out, fault_en, fault_site, fault_sa,
      input  res_valid, res_site, res_sa, res_det, res_vec, det_count,
      output golden_in, faulty_in, res_ready
   );

endinterface

// File: rtl/fault_sim_sequencer_settle_timer.sv
// settle_timer: counts the settle wait after a vector is applied.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : reload with SETTLE_CYC (asserted in APPLY)
//   run_i        : count down (asserted in SETTLE)
//   expired_o    : high on the last settle cycle
// The counter is at least one bit wide so SETTLE_CYC of 0 or 1 still builds;
// with SETTLE_CYC = 0 the sequencer never enters SETTLE.
module settle_timer #(
   parameter int SETTLE_CYC = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic run_i,
   output logic expired_o
);

   localparam int TW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
   localparam logic [TW-1:0] LOAD_VAL = TW'(SETTLE_CYC);

   logic [TW-1:0] cnt_q, cnt_d;

   // Next count: reload, decrement while running, otherwise hold.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (run_i && (cnt_q != {TW{1'b0}})) begin
         cnt_d = cnt_q - TW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= {TW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Count of 1 means this is the final settle cycle.
   assign expired_o = (cnt_q <= TW'(1));

endmodule

// File: rtl/fault_sim_sequencer.sv
// fault_sim_sequencer: serial stuck-at fault campaign controller.
// Walks faults (site0 sa0, site0 sa1, site1 sa0, ...), applies exhaustive
// vectors to golden and faulty netlists, stops a fault at its first
// detecting vector and reports each fault over a valid/ready handshake.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   start_i            : begin a campaign (only honoured in IDLE)
//   abort_i            : cancel the campaign (any non-IDLE state)
//   busy_o             : high outside IDLE
//   done_o             : one-cycle pulse on normal completion
//   bus (master)       : stimulus, injection control, netlist outputs, results
module fault_sim_sequencer
   import fault_sim_pkg::*;
#(
   parameter int SETTLE_CYC = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i,
   input  logic abort_i,
   output logic busy_o,
   output logic done_o,
   fault_sim_sequencer_if.master bus
);

   localparam logic [N_IN-1:0] VEC_MAX = {N_IN{1'b1}};

   state_e            state_q, state_d;
   logic [N_IN-1:0]   vec_q, vec_d;
   logic [SITE_W-1:0] site_q, site_d;
   logic              sa_q, sa_d;
   result_t           res_q, res_d;
   logic [CNT_W-1:0]  det_q, det_d;
   logic              busy_q, done_q, fault_en_q, res_valid_q;

   logic timer_load_s;
   logic timer_run_s;
   logic timer_expired_s;
   logic mismatch_s;

   settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_settle_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (timer_load_s),
      .run_i     (timer_run_s),
      .expired_o (timer_expired_s)
   );

   assign mismatch_s  = (bus.golden_in != bus.faulty_in);
   assign timer_load_s = (state_q == APPLY);
   assign timer_run_s  = (state_q == SETTLE);

   // Next-state and datapath updates of the campaign FSM.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      site_d  = site_q;
      sa_d    = sa_q;
      res_d   = res_q;
      det_d   = det_q;

      // Abort overrides everything, including a simultaneous handshake.
      if ((state_q != IDLE) && abort_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_d = INJECT;
                  det_d   = {CNT_W{1'b0}};
                  site_d  = {SITE_W{1'b0}};
                  sa_d    = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
            INJECT: begin
               vec_d   = {N_IN{1'b0}};
               state_d = APPLY;
            end
            APPLY: begin
               state_d = (SETTLE_CYC == 0) ? COMPARE : SETTLE;
            end
            SETTLE: begin
               if (timer_expired_s) begin
                  state_d = COMPARE;
               end else begin
                  state_d = SETTLE;
               end
            end
            COMPARE: begin
               if (mismatch_s) begin
                  // Early exit: first detecting vector ends this fault.
                  res_d   = '{site: site_q, sa: sa_q, det: 1'b1, vec: vec_q};
                  state_d = REPORT;
                  if (det_q < CNT_W'(N_REPORTS)) begin
                     det_d = det_q + CNT_W'(1);
                  end else begin
                     det_d = det_q;
                  end
               end else if (vec_q != VEC_MAX) begin
                  vec_d   = vec_q + N_IN'(1);
                  state_d = APPLY;
               end else begin
                  res_d   = '{site: site_q, sa: sa_q, det: 1'b0, vec: {N_IN{1'b0}}};
                  state_d = REPORT;
               end
            end
            REPORT: begin
               if (bus.res_ready) begin
                  if (is_last_fault(site_q, sa_q)) begin
                     state_d = DONE;
                  end else begin
                     state_d = INJECT;
                     if (sa_q) begin
                        site_d = site_q + SITE_W'(1);
                        sa_d   = 1'b0;
                     end else begin
                        sa_d   = 1'b1;
                     end
                  end
               end else begin
                  state_d = REPORT;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, datapath and output registers; status flags follow the next state
   // so they line up with the state they describe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         vec_q       <= {N_IN{1'b0}};
         site_q      <= {SITE_W{1'b0}};
         sa_q        <= 1'b0;
         res_q       <= '{site: {SITE_W{1'b0}}, sa: 1'b0, det: 1'b0, vec: {N_IN{1'b0}}};
         det_q       <= {CNT_W{1'b0}};
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fault_en_q  <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         site_q      <= site_d;
         sa_q        <= sa_d;
         res_q       <= res_d;
         det_q       <= det_d;
         busy_q      <= (state_d != IDLE);
         done_q      <= (state_d == DONE);
         fault_en_q  <= (state_d != IDLE) && (state_d != DONE);
         res_valid_q <= (state_d == REPORT);
      end
   end

   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign bus.vec_out    = vec_q;
   assign bus.fault_en   = fault_en_q;
   assign bus.fault_site = site_q;
   assign bus.fault_sa   = sa_q;
   assign bus.res_valid  = res_valid_q;
   assign bus.res_site   = res_q.site;
   assign bus.res_sa     = res_q.sa;
   assign bus.res_det    = res_q.det;
   assign bus.res_vec    = res_q.vec;
   assign bus.det_count  = det_q;

endmodule

// File: tb/tb_fault_sim_sequencer.sv
// Directed bench for fault_sim_sequencer. Netlist pair modelled as a full
// adder {carry,sum}; faulty output = golden ^ mask chosen by 'mode':
//   0 fault-free, 1 sum flipped only for site4 sa1 at vec 5, 2 all outputs
//   flipped whenever a fault is injected. dut2 is a SETTLE_CYC=0 build.
module tb_fault_sim_sequencer;
   import fault_sim_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start1, abort1, start2, abort2, ready1;
   logic busy1, done1, busy2, done2;
   logic [1:0] mask1;
   int mode;
   int cyc;
   int n_tests = 0;
   int n_fail  = 0;

   fault_sim_sequencer_if bus1();
   fault_sim_sequencer_if bus2();

   function automatic logic [1:0] golden_f(input logic [2:0] v);
      return {(v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]), ^v};
   endfunction

   always_comb begin
      mask1 = 2'b00;
      if (bus1.fault_en) begin
         if (mode == 1 && bus1.fault_site == 5'd4 && bus1.fault_sa && bus1.vec_out == 3'd5)
            mask1 = 2'b01;
         else if (mode == 2)
            mask1 = 2'b11;
      end
   end

   assign bus1.golden_in = golden_f(bus1.vec_out);
   assign bus1.faulty_in = golden_f(bus1.vec_out) ^ mask1;
   assign bus1.res_ready = ready1;
   assign bus2.golden_in = golden_f(bus2.vec_out);
   assign bus2.faulty_in = golden_f(bus2.vec_out);
   assign bus2.res_ready = 1'b1;

   fault_sim_sequencer #(.SETTLE_CYC(2)) dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start1), .abort_i(abort1),
      .busy_o(busy1), .done_o(done1), .bus(bus1)
   );

   fault_sim_sequencer #(.SETTLE_CYC(0)) dut2 (
      .clk_i(clk), .rst_i(rst), .start_i(start2), .abort_i(abort2),
      .busy_o(busy2), .done_o(done2), .bus(bus2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step1();
      @(negedge clk);
      cyc++;
   endtask

   // Start pulse is cycle 0; returns at cycle 1 (first INJECT cycle).
   task automatic begin1();
      @(negedge clk);
      start1 = 1'b1;
      cyc = 0;
      @(negedge clk);
      start1 = 1'b0;
      cyc = 1;
   endtask

   task automatic run_campaign(input int exp_done, input int exp_det);
      int  idx = 0;
      int  done_cyc = -1;
      bit  saw6 = 1'b0;
      while (done_cyc < 0 && cyc < 4000) begin
         if (bus1.res_valid && ready1) begin
            chk("rep_site", 32'(bus1.res_site), 32'(idx / 2));
            chk("rep_sa", 32'(bus1.res_sa), 32'(idx % 2));
            if (mode == 1 && idx == 9) begin
               chk("rep_det9", 32'(bus1.res_det), 32'd1);
               chk("rep_vec9", 32'(bus1.res_vec), 32'd5);
            end else begin
               chk("rep_det", 32'(bus1.res_det), 32'd0);
               chk("rep_vec", 32'(bus1.res_vec), 32'd0);
            end
            if (mode == 0) chk("rep_cyc", 32'(cyc), 32'(34 * (idx + 1)));
            idx++;
         end
         if (bus1.fault_en && bus1.fault_site == 5'd4 && bus1.fault_sa && bus1.vec_out == 3'd6)
            saw6 = 1'b1;
         if (done1) done_cyc = cyc;
         if (done_cyc < 0) step1();
      end
      chk("rep_count", 32'(idx), 32'd42);
      chk("done_cyc", 32'(done_cyc), 32'(exp_done));
      chk("det_count", 32'(bus1.det_count), 32'(exp_det));
      chk("fault_en_done", 32'(bus1.fault_en), 32'd0);
      if (mode == 1) chk("vec6_after_det", 32'(saw6), 32'd0);
      step1();
      chk("done_pulse", 32'(done1), 32'd0);
      chk("busy_after", 32'(busy1), 32'd0);
      chk("det_hold", 32'(bus1.det_count), 32'(exp_det));
   endtask

   initial begin
      int c2, first_rep, n_rep2, done2_cyc, v4, v16;
      logic [31:0] snap_site, snap_sa, snap_vec, snap_fsite;
      bit stable, saw_done;

      rst = 1'b1; start1 = 1'b0; abort1 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
      ready1 = 1'b1; mode = 0; cyc = 0;
      repeat (3) @(negedge clk);
      // Reset state
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_done", 32'(done1), 32'd0);
      chk("rst_fault_en", 32'(bus1.fault_en), 32'd0);
      chk("rst_res_valid", 32'(bus1.res_valid), 32'd0);
      chk("rst_vec", 32'(bus1.vec_out), 32'd0);
      chk("rst_site", 32'(bus1.fault_site), 32'd0);
      chk("rst_det_count", 32'(bus1.det_count), 32'd0);
      chk("rst_res_vec", 32'(bus1.res_vec), 32'd0);
      rst = 1'b0;

      // 1: fault-free campaign
      mode = 0;
      begin1();
      run_campaign(1429, 0);

      // 2: single detection at site4 sa1, vec 5 (fault ends 8 cycles early)
      mode = 1;
      begin1();
      run_campaign(1421, 1);

      // 3: res_ready held low during report #0
      mode = 0; ready1 = 1'b0;
      begin1();
      while (!bus1.res_valid && cyc < 100) step1();
      chk("t3_valid", 32'(bus1.res_valid), 32'd1);
      chk("t3_cyc", 32'(cyc), 32'd34);
      snap_site = 32'(bus1.res_site); snap_sa = 32'(bus1.res_sa);
      snap_vec = 32'(bus1.res_vec); snap_fsite = 32'(bus1.fault_site);
      chk("t3_det", 32'(bus1.res_det), 32'd0);
      chk("t3_vec_out", 32'(bus1.vec_out), 32'd7);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step1();
         if (!bus1.res_valid || 32'(bus1.res_site) != snap_site || 32'(bus1.res_sa) != snap_sa ||
             32'(bus1.res_vec) != snap_vec || 32'(bus1.fault_site) != snap_fsite ||
             bus1.vec_out != 3'd7 || !bus1.fault_en)
            stable = 1'b0;
      end
      chk("t3_stable", 32'(stable), 32'd1);
      ready1 = 1'b1;
      step1();
      chk("t3_next_site", 32'(bus1.fault_site), 32'd0);
      chk("t3_next_sa", 32'(bus1.fault_sa), 32'd1);
      chk("t3_valid_drop", 32'(bus1.res_valid), 32'd0);
      abort1 = 1'b1; step1(); abort1 = 1'b0;
      chk("t3_abort_busy", 32'(busy1), 32'd0);

      // 4: abort during SETTLE of site3 (every fault detected at vec 0)
      mode = 2;
      begin1();
      while (cyc < 39) step1();
      chk("t4_site", 32'(bus1.fault_site), 32'd3);
      chk("t4_sa", 32'(bus1.fault_sa), 32'd0);
      abort1 = 1'b1; step1(); abort1 = 1'b0;
      chk("t4_busy", 32'(busy1), 32'd0);
      chk("t4_fault_en", 32'(bus1.fault_en), 32'd0);
      chk("t4_res_valid", 32'(bus1.res_valid), 32'd0);
      chk("t4_det_hold", 32'(bus1.det_count), 32'd6);
      saw_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (done1) saw_done = 1'b1;
         step1();
      end
      chk("t4_no_done", 32'(saw_done), 32'd0);
      begin1();
      chk("t4_restart_site", 32'(bus1.fault_site), 32'd0);
      chk("t4_restart_sa", 32'(bus1.fault_sa), 32'd0);
      chk("t4_restart_det", 32'(bus1.det_count), 32'd0);
      chk("t4_restart_en", 32'(bus1.fault_en), 32'd1);

      // 5: start while busy is ignored; rst mid-REPORT
      while (cyc < 8) step1();
      start1 = 1'b1; step1(); start1 = 1'b0;
      while (cyc < 13) step1();
      chk("t5_site", 32'(bus1.fault_site), 32'd1);
      chk("t5_sa", 32'(bus1.fault_sa), 32'd0);
      while (cyc < 18) step1();
      chk("t5_in_report", 32'(bus1.res_valid), 32'd1);
      chk("t5_det_pre", 32'(bus1.det_count), 32'd3);
      rst = 1'b1; step1(); rst = 1'b0;
      chk("t5_rst_valid", 32'(bus1.res_valid), 32'd0);
      chk("t5_rst_busy", 32'(busy1), 32'd0);
      chk("t5_rst_det", 32'(bus1.det_count), 32'd0);
      chk("t5_rst_en", 32'(bus1.fault_en), 32'd0);
      chk("t5_rst_site", 32'(bus1.fault_site), 32'd0);
      chk("t5_rst_res_site", 32'(bus1.res_site), 32'd0);

      // 6: SETTLE_CYC=0 build, fault-free, 18 cycles per fault
      @(negedge clk); start2 = 1'b1; c2 = 0;
      @(negedge clk); start2 = 1'b0; c2 = 1;
      first_rep = -1; n_rep2 = 0; done2_cyc = -1; v4 = -1; v16 = -1;
      while (done2_cyc < 0 && c2 < 2000) begin
         if (bus2.res_valid) begin
            if (first_rep < 0) first_rep = c2;
            n_rep2++;
         end
         if (c2 == 4) v4 = int'(bus2.vec_out);
         if (c2 == 16) v16 = int'(bus2.vec_out);
         if (done2) done2_cyc = c2;
         else begin
            @(negedge clk);
            c2++;
         end
      end
      chk("t6_vec_c4", 32'(v4), 32'd1);
      chk("t6_vec_c16", 32'(v16), 32'd7);
      chk("t6_first_rep", 32'(first_rep), 32'd18);
      chk("t6_rep_count", 32'(n_rep2), 32'd42);
      chk("t6_done_cyc", 32'(done2_cyc), 32'd757);
      chk("t6_det_count", 32'(bus2.det_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
